// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial framer.
// Frame-length and parity helpers are usable in constant expressions.
package serial_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic int frame_len(input int width, input int parity_en);
        return width + ((parity_en != 0) ? 1 : 0);
    endfunction

    function automatic logic even_par(input logic [31:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Bit-position counter for one serial frame.
// Clear has priority over enable; tc flags the last bit position.
module ser_bit_counter
    import serial_pkg::*;
#(
    parameter int FRAME = 4,
    parameter int CW    = $clog2(FRAME + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_en,
    output logic [CW-1:0] o_count,
    output logic          o_tc
);

    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == LAST);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out framer with optional even parity.
// Words stream back-to-back when a new word is offered on the last bit.
module piso_serializer
    import serial_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 0,
    parameter int PARITY_EN = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int FRAME = frame_len(WIDTH, PARITY_EN);
    localparam int CW    = $clog2(FRAME + 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic             r_par;
    logic             r_sout;
    logic             r_sout_valid;
    logic             r_busy;
    logic             r_done;

    logic [CW-1:0]    w_count;
    logic             w_tc;
    logic             w_last;
    logic             w_accept;
    logic             w_clr;
    logic             w_en;

    assign w_last     = (r_state == SHIFT) && w_tc;
    assign load_ready = !rst && ((r_state == IDLE) || w_last);
    assign w_accept   = load_valid && load_ready;
    assign w_clr      = w_accept || w_last;
    assign w_en       = (r_state == SHIFT);

    ser_bit_counter #(
        .FRAME (FRAME),
        .CW    (CW)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .i_en    (w_en),
        .o_count (w_count),
        .o_tc    (w_tc)
    );

    // w_count is the index of the bit on sout now; load the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_shreg      <= '0;
            r_par        <= 1'b0;
            r_sout       <= 1'b0;
            r_sout_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else if (w_accept) begin
            r_state      <= SHIFT;
            r_shreg      <= din;
            r_par        <= even_par(32'(din));
            r_sout       <= (MSB_FIRST != 0) ? din[WIDTH-1] : din[0];
            r_sout_valid <= 1'b1;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
        end else if (w_last) begin
            r_state      <= IDLE;
            r_sout       <= 1'b0;
            r_sout_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else if (r_state == SHIFT) begin
            if (MSB_FIRST != 0) begin
                r_shreg <= r_shreg << 1;
                r_sout  <= r_shreg[WIDTH-2];
            end else begin
                r_shreg <= r_shreg >> 1;
                r_sout  <= r_shreg[1];
            end
            if ((PARITY_EN != 0) && (w_count == CW'(WIDTH - 1))) begin
                r_sout <= r_par;
            end
            r_done <= (w_count == CW'(FRAME - 2));
        end
    end

    assign sout       = r_sout;
    assign sout_valid = r_sout_valid;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: LSB-first plain instance and
// an MSB-first instance with parity, sharing clock, reset and data.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] din = 4'b0000;
    logic       a_lv = 1'b0;
    logic       b_lv = 1'b0;

    logic a_rdy, a_sout, a_sv, a_busy, a_done;
    logic b_rdy, b_sout, b_sv, b_busy, b_done;

    int n_tot = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    piso_serializer #(
        .WIDTH(4), .MSB_FIRST(0), .PARITY_EN(0)
    ) u_a (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .load_valid (a_lv),
        .load_ready (a_rdy),
        .sout       (a_sout),
        .sout_valid (a_sv),
        .busy       (a_busy),
        .done       (a_done)
    );

    piso_serializer #(
        .WIDTH(4), .MSB_FIRST(1), .PARITY_EN(1)
    ) u_b (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .load_valid (b_lv),
        .load_ready (b_rdy),
        .sout       (b_sout),
        .sout_valid (b_sv),
        .busy       (b_busy),
        .done       (b_done)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp8;
        logic [4:0] exp5;
        logic [3:0] q;

        // 1: reset
        tick();
        tick();
        chk("rst_sout", a_sout, 0);
        chk("rst_sv", a_sv, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_rdy", a_rdy, 0);
        rst = 1'b0;
        tick();
        chk("rdy_after_rst", a_rdy, 1);
        chk("b_rdy_after_rst", b_rdy, 1);

        // 2: LSB-first 1011 -> 1,1,0,1
        din  = 4'b1011;
        a_lv = 1'b1;
        tick();
        a_lv = 1'b0;
        din  = 4'b0000;
        q    = 4'b0000;
        exp8 = 8'b0000_1011;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("lsb_sout%0d", i), a_sout, exp8[i]);
            chk($sformatf("lsb_sv%0d", i), a_sv, 1);
            chk($sformatf("lsb_busy%0d", i), a_busy, 1);
            chk($sformatf("lsb_done%0d", i), a_done, (i == 3));
            if (a_sv) q = {a_sout, q[3:1]};
            tick();
        end
        chk("lsb_q", q, 4'b1011);
        chk("lsb_idle_sv", a_sv, 0);
        chk("lsb_idle_busy", a_busy, 0);
        chk("lsb_idle_sout", a_sout, 0);
        chk("lsb_idle_rdy", a_rdy, 1);

        // 3: MSB-first with parity, 1011 -> 1,0,1,1,1
        din  = 4'b1011;
        b_lv = 1'b1;
        tick();
        b_lv = 1'b0;
        din  = 4'b0000;
        exp5 = 5'b11101;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("msb_sout%0d", i), b_sout, exp5[i]);
            chk($sformatf("msb_busy%0d", i), b_busy, 1);
            chk($sformatf("msb_done%0d", i), b_done, (i == 4));
            tick();
        end
        chk("msb_idle_busy", b_busy, 0);
        chk("msb_idle_sv", b_sv, 0);

        // 4: back-to-back 1011 then 0110
        din  = 4'b1011;
        a_lv = 1'b1;
        tick();
        din  = 4'b0110;
        exp8 = 8'b0110_1011;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) a_lv = 1'b0;
            chk($sformatf("b2b_sout%0d", i), a_sout, exp8[i]);
            chk($sformatf("b2b_sv%0d", i), a_sv, 1);
            chk($sformatf("b2b_done%0d", i), a_done, (i == 3 || i == 7));
            tick();
        end
        chk("b2b_end_sv", a_sv, 0);

        // 5: load while busy is ignored
        din  = 4'b0000;
        a_lv = 1'b1;
        tick();
        a_lv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                din  = 4'b1111;
                a_lv = 1'b1;
                chk("busy_rdy", a_rdy, 0);
            end else begin
                a_lv = 1'b0;
            end
            chk($sformatf("busy_sout%0d", i), a_sout, 0);
            chk($sformatf("busy_sv%0d", i), a_sv, 1);
            tick();
        end
        a_lv = 1'b0;
        chk("busy_end_sv", a_sv, 0);
        chk("busy_end_busy", a_busy, 0);
        tick();
        chk("busy_stay_idle", a_sv, 0);

        // 6: mid-frame reset
        din  = 4'b1011;
        a_lv = 1'b1;
        tick();
        a_lv = 1'b0;
        chk("mid_first", a_sout, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_sout", a_sout, 0);
        chk("mid_sv", a_sv, 0);
        chk("mid_busy", a_busy, 0);
        chk("mid_done", a_done, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("mid_nodone%0d", i), a_done | a_sv, 0);
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
